// File: rtl/multicycle_control_if.sv
// Bundle of decoder, memory handshake and datapath control signals for multicycle_control.
// master: the control FSM (drives datapath controls, samples decoder flags and mem_ready).
// slave:  the datapath/memory side (drives instr, class flags, mem_ready; observes controls).
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM;
    logic             mem_ready;
    logic             mem_req;
    logic             MemRead, MemWrite, MemtoReg, ALUSrc, BranchSig, Jump;
    logic [1:0]       ALUOp;
    logic [2:0]       ImmSrc;
    logic             IRWrite, RegWrite, PCWrite;
    logic             halt, trap;
    logic [1:0]       trap_cause;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  instr, ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM,
        input  mem_ready,
        output mem_req, MemRead, MemWrite, MemtoReg, ALUSrc, BranchSig, Jump,
        output ALUOp, ImmSrc, IRWrite, RegWrite, PCWrite,
        output halt, trap, trap_cause, state, instret
    );

    modport slave (
        output instr, ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, SYSTEM,
        output mem_ready,
        input  mem_req, MemRead, MemWrite, MemtoReg, ALUSrc, BranchSig, Jump,
        input  ALUOp, ImmSrc, IRWrite, RegWrite, PCWrite,
        input  halt, trap, trap_cause, state, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with HALT and TRAP sinks.
// Latency (zero wait): ALU/JAL/JALR/LUI/AUIPC 4, Load 5, Store 4, Branch 3 cycles per instruction.
// Waits in FETCH/MEM while mem_ready is low; TIMEOUT consecutive idle cycles trap (cause 10).
// Ports: clk, rst (synchronous, active-high), bus (multicycle_control_if.master).
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        C_NONE, C_ALUREG, C_ALUIMM, C_BRANCH, C_JAL, C_JALR,
        C_LUI, C_AUIPC, C_LOAD, C_STORE, C_SYSTEM
    } cls_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [1:0] CAUSE_ILL = 2'b01;
    localparam logic [1:0] CAUSE_BUS = 2'b10;

    // The wait counter only ever holds 0..TIMEOUT-1: the idle cycle that would
    // reach TIMEOUT leaves the state instead, which clears the counter.
    localparam int               WCW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WCW-1:0]   WAIT_LAST = WCW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, dec_cls;
    logic [1:0]       cause_q, cause_d;
    logic [WCW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [9:0] flags;
    logic [2:0] funct3;
    logic       dec_legal;

    logic [1:0] ex_aluop;
    logic       ex_alusrc;
    logic [2:0] ex_imm;

    logic       mem_req_c, mem_read_c, mem_write_c, mem_to_reg_c, alu_src_c;
    logic       branch_c, jump_c, ir_write_c, reg_write_c, pc_write_c, halt_c, trap_c;
    logic [1:0] alu_op_c;
    logic [2:0] imm_src_c;

    assign flags  = {bus.SYSTEM, bus.Store, bus.Load, bus.AUIPC, bus.LUI,
                     bus.JALR, bus.JAL, bus.Branch, bus.ALUimm, bus.ALUreg};
    assign funct3 = bus.instr[14:12];

    // Only a single set flag names a class; anything else stays C_NONE (illegal).
    always_comb begin
        dec_cls = C_NONE;
        case (flags)
            10'b00_0000_0001: dec_cls = C_ALUREG;
            10'b00_0000_0010: dec_cls = C_ALUIMM;
            10'b00_0000_0100: dec_cls = C_BRANCH;
            10'b00_0000_1000: dec_cls = C_JAL;
            10'b00_0001_0000: dec_cls = C_JALR;
            10'b00_0010_0000: dec_cls = C_LUI;
            10'b00_0100_0000: dec_cls = C_AUIPC;
            10'b00_1000_0000: dec_cls = C_LOAD;
            10'b01_0000_0000: dec_cls = C_STORE;
            10'b10_0000_0000: dec_cls = C_SYSTEM;
            default:          dec_cls = C_NONE;
        endcase
        dec_legal = (dec_cls != C_NONE) && !((dec_cls == C_JALR) && (funct3 != 3'b000));
    end

    // ALU controls set up in EXEC and held through MEM for loads/stores.
    always_comb begin
        ex_aluop  = 2'b00;
        ex_alusrc = 1'b0;
        ex_imm    = IMM_I;
        case (cls_q)
            C_ALUREG: ex_aluop = 2'b10;
            C_ALUIMM: begin ex_aluop = 2'b10; ex_alusrc = 1'b1; ex_imm = IMM_I; end
            C_LOAD:   begin ex_alusrc = 1'b1; ex_imm = IMM_I; end
            C_STORE:  begin ex_alusrc = 1'b1; ex_imm = IMM_S; end
            C_BRANCH: begin ex_aluop = 2'b01; ex_imm = IMM_B; end
            C_JAL:    begin ex_alusrc = 1'b1; ex_imm = IMM_J; end
            C_JALR:   begin ex_alusrc = 1'b1; ex_imm = IMM_I; end
            C_LUI:    begin ex_aluop = 2'b11; ex_alusrc = 1'b1; ex_imm = IMM_U; end
            C_AUIPC:  begin ex_alusrc = 1'b1; ex_imm = IMM_U; end
            default:  ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        cause_d      = cause_q;
        instret_d    = instret_q;
        cnt_d        = cnt_q;
        mem_req_c    = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_c    = 1'b0;
        branch_c     = 1'b0;
        jump_c       = 1'b0;
        alu_op_c     = 2'b00;
        imm_src_c    = 3'b000;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        pc_write_c   = 1'b0;
        halt_c       = 1'b0;
        trap_c       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                mem_read_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (!dec_legal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILL;
                end else if (dec_cls == C_SYSTEM) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op_c  = ex_aluop;
                alu_src_c = ex_alusrc;
                imm_src_c = ex_imm;
                jump_c    = (cls_q == C_JAL) || (cls_q == C_JALR);
                if ((cls_q == C_LOAD) || (cls_q == C_STORE)) begin
                    state_d = S_MEM;
                end else if (cls_q == C_BRANCH) begin
                    branch_c   = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c   = 1'b1;
                mem_read_c  = (cls_q == C_LOAD);
                mem_write_c = (cls_q == C_STORE);
                alu_op_c    = ex_aluop;
                alu_src_c   = ex_alusrc;
                imm_src_c   = ex_imm;
                if (bus.mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_write_c = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                pc_write_c   = 1'b1;
                mem_to_reg_c = (cls_q == C_LOAD);
                jump_c       = (cls_q == C_JAL) || (cls_q == C_JALR);
                state_d      = S_FETCH;
            end
            S_HALT:  halt_c = 1'b1;
            S_TRAP:  trap_c = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // Any state change is an entry into a fresh wait window.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_req_c && !bus.mem_ready) begin
            cnt_d = cnt_q + WCW'(1);
        end

        if (pc_write_c) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            cause_q   <= 2'b00;
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
        end
    end

    // Controls are masked while rst is high so a pending memory write is
    // abandoned and no fetch is requested until rst has been released.
    assign bus.mem_req    = mem_req_c    & ~rst;
    assign bus.MemRead    = mem_read_c   & ~rst;
    assign bus.MemWrite   = mem_write_c  & ~rst;
    assign bus.MemtoReg   = mem_to_reg_c & ~rst;
    assign bus.ALUSrc     = alu_src_c    & ~rst;
    assign bus.BranchSig  = branch_c     & ~rst;
    assign bus.Jump       = jump_c       & ~rst;
    assign bus.ALUOp      = rst ? 2'b00 : alu_op_c;
    assign bus.ImmSrc     = rst ? 3'b000 : imm_src_c;
    assign bus.IRWrite    = ir_write_c   & ~rst;
    assign bus.RegWrite   = reg_write_c  & ~rst;
    assign bus.PCWrite    = pc_write_c   & ~rst;
    assign bus.halt       = halt_c       & ~rst;
    assign bus.trap       = trap_c       & ~rst;
    assign bus.trap_cause = cause_q;
    assign bus.state      = state_q;
    assign bus.instret    = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle traces are built
// from the instruction-class rules (phases, wait budgets, control table) and
// compared cycle by cycle with the DUT, including the retired-instruction count.
module tb_multicycle_control;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    // Flag bit positions in the bench's flag vector.
    localparam int F_ALUREG = 0, F_ALUIMM = 1, F_BRANCH = 2, F_JAL = 3, F_JALR = 4;
    localparam int F_LUI = 5, F_AUIPC = 6, F_LOAD = 7, F_STORE = 8, F_SYSTEM = 9;

    // Expected EXEC controls per class index (order as the flag positions above).
    // ImmSrc codes: I=000 S=001 B=010 J=011 U=100.
    localparam logic [1:0] AOP  [0:8] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
    localparam logic       ASRC [0:8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [2:0] IMM  [0:8] = '{3'b000, 3'b000, 3'b010, 3'b011, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, mrd, mwr, m2r, asrc, bsig, jmp;
        logic [1:0] aop;
        logic [2:0] imm;
        logic       irw, rgw, pcw, hlt, trp;
        logic [1:0] cause;
    } ctl_t;

    typedef struct packed {
        logic rdy;
        ctl_t c;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus_if ();

    multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [CNT_W-1:0] exp_instret = '0;
    cyc_t           q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t obs();
        ctl_t o;
        o.st    = bus_if.state;
        o.mreq  = bus_if.mem_req;
        o.mrd   = bus_if.MemRead;
        o.mwr   = bus_if.MemWrite;
        o.m2r   = bus_if.MemtoReg;
        o.asrc  = bus_if.ALUSrc;
        o.bsig  = bus_if.BranchSig;
        o.jmp   = bus_if.Jump;
        o.aop   = bus_if.ALUOp;
        o.imm   = bus_if.ImmSrc;
        o.irw   = bus_if.IRWrite;
        o.rgw   = bus_if.RegWrite;
        o.pcw   = bus_if.PCWrite;
        o.hlt   = bus_if.halt;
        o.trp   = bus_if.trap;
        o.cause = bus_if.trap_cause;
        return o;
    endfunction

    function automatic ctl_t mk(input logic [2:0] st);
        ctl_t c;
        c    = '0;
        c.st = st;
        return c;
    endfunction

    function automatic logic [9:0] fbit(input int k);
        logic [9:0] one;
        one = 10'd1;
        return one << k;
    endfunction

    task automatic push(input logic rdy, input ctl_t c);
        cyc_t e;
        e.rdy = rdy;
        e.c   = c;
        q.push_back(e);
    endtask

    task automatic tail(input logic [2:0] st, input logic [1:0] cause);
        ctl_t c;
        for (int i = 0; i < 3; i++) begin
            c       = mk(st);
            c.hlt   = (st == 3'd5);
            c.trp   = (st == 3'd6);
            c.cause = cause;
            push(1'($urandom), c);
        end
    endtask

    task automatic play(input int cut, input string name);
        cyc_t e;
        int   n;
        n = 0;
        while (q.size() > 0 && (cut < 0 || n < cut)) begin
            e = q.pop_front();
            bus_if.mem_ready = e.rdy;
            @(negedge clk);
            chk($sformatf("%s.c%0d", name, n), {6'd0, obs(), bus_if.instret}, {6'd0, e.c, exp_instret});
            if (e.c.pcw) exp_instret = exp_instret + 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        bus_if.mem_ready = 1'($urandom);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({name, ".rst"}, {6'd0, obs(), bus_if.instret}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_instret = '0;
    endtask

    // Builds the expected trace of one instruction from the class rules, then plays it.
    task automatic run_instr(input logic [9:0] fl, input logic [2:0] f3, input int df,
                             input int dm, input int cut, input string name);
        ctl_t       c;
        logic [31:0] iw;
        bit         absorb;
        int         k;
        absorb = 0;
        k      = 0;
        iw     = $urandom;
        iw[14:12] = f3;
        bus_if.instr  = iw;
        bus_if.ALUreg = fl[F_ALUREG]; bus_if.ALUimm = fl[F_ALUIMM];
        bus_if.Branch = fl[F_BRANCH]; bus_if.JAL    = fl[F_JAL];
        bus_if.JALR   = fl[F_JALR];   bus_if.LUI    = fl[F_LUI];
        bus_if.AUIPC  = fl[F_AUIPC];  bus_if.Load   = fl[F_LOAD];
        bus_if.Store  = fl[F_STORE];  bus_if.SYSTEM = fl[F_SYSTEM];

        for (int i = 0; i < df && i < TIMEOUT; i++) begin
            c = mk(3'd0); c.mreq = 1'b1; c.mrd = 1'b1;
            push(1'b0, c);
        end
        if (df >= TIMEOUT) begin
            tail(3'd6, 2'b10);
            absorb = 1;
        end else begin
            c = mk(3'd0); c.mreq = 1'b1; c.mrd = 1'b1; c.irw = 1'b1;
            push(1'b1, c);
            push(1'($urandom), mk(3'd1));
            if ($countones(fl) != 1 || (fl[F_JALR] && f3 != 3'b000)) begin
                tail(3'd6, 2'b01);
                absorb = 1;
            end else if (fl[F_SYSTEM]) begin
                tail(3'd5, 2'b00);
                absorb = 1;
            end else begin
                for (int i = 0; i < 9; i++) if (fl[i]) k = i;
                c = mk(3'd2);
                c.aop  = AOP[k];
                c.asrc = ASRC[k];
                c.imm  = IMM[k];
                c.jmp  = (k == F_JAL || k == F_JALR);
                if (k == F_BRANCH) begin
                    c.bsig = 1'b1;
                    c.pcw  = 1'b1;
                end
                push(1'($urandom), c);
                if (k == F_LOAD || k == F_STORE) begin
                    c.st   = 3'd3;
                    c.mreq = 1'b1;
                    c.mrd  = (k == F_LOAD);
                    c.mwr  = (k == F_STORE);
                    for (int i = 0; i < dm && i < TIMEOUT; i++) push(1'b0, c);
                    if (dm >= TIMEOUT) begin
                        tail(3'd6, 2'b10);
                        absorb = 1;
                    end else begin
                        c.pcw = (k == F_STORE);
                        push(1'b1, c);
                    end
                end
                if (k != F_BRANCH && k != F_STORE && !absorb) begin
                    c = mk(3'd4);
                    c.rgw = 1'b1;
                    c.pcw = 1'b1;
                    c.m2r = (k == F_LOAD);
                    c.jmp = (k == F_JAL || k == F_JALR);
                    push(1'($urandom), c);
                end
            end
        end
        play(cut, name);
        if (absorb || cut >= 0) do_reset(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] fl;
        logic [2:0] f3;
        int         r, a, b, df, dm;

        bus_if.instr = '0;
        bus_if.mem_ready = 1'b0;
        {bus_if.ALUreg, bus_if.ALUimm, bus_if.Branch, bus_if.JAL, bus_if.JALR,
         bus_if.LUI, bus_if.AUIPC, bus_if.Load, bus_if.Store, bus_if.SYSTEM} = '0;
        do_reset("init");

        // Directed: main classes, waits, timeouts, illegal decodes.
        run_instr(fbit(F_ALUREG), 3'd0, 0, 0, -1, "alureg");
        run_instr(fbit(F_LOAD),   3'd2, 0, 3, -1, "load_wait3");
        run_instr(fbit(F_STORE),  3'd2, 0, 0, -1, "store");
        run_instr(fbit(F_BRANCH), 3'd1, 0, 0, -1, "branch");
        run_instr(fbit(F_ALUREG), 3'd0, TIMEOUT - 1, 0, -1, "fetch_edge");
        run_instr(fbit(F_STORE),  3'd0, 1, TIMEOUT - 1, -1, "mem_edge");
        run_instr(fbit(F_ALUIMM), 3'd0, 0, 0, -1, "aluimm");
        run_instr(fbit(F_JAL),    3'd5, 0, 0, -1, "jal");
        run_instr(fbit(F_JALR),   3'd0, 0, 0, -1, "jalr");
        run_instr(fbit(F_LUI),    3'd7, 0, 0, -1, "lui");
        run_instr(fbit(F_AUIPC),  3'd3, 0, 0, -1, "auipc");
        run_instr(fbit(F_ALUREG), 3'd0, TIMEOUT, 0, -1, "fetch_timeout");
        run_instr(fbit(F_LOAD),   3'd0, 0, TIMEOUT, -1, "mem_timeout");
        run_instr(fbit(F_JALR),   3'd1, 0, 0, -1, "jalr_f3");
        run_instr(fbit(F_ALUREG) | fbit(F_LOAD), 3'd0, 0, 0, -1, "two_flags");
        run_instr(10'd0,          3'd0, 0, 0, -1, "no_flags");
        run_instr(fbit(F_SYSTEM), 3'd0, 0, 0, -1, "system");
        run_instr(fbit(F_STORE),  3'd0, 0, 3, 4, "rst_in_mem");

        // Counter wrap at 2^CNT_W retired instructions.
        for (int i = 0; i < 16; i++) run_instr(fbit(F_ALUREG), 3'd0, 0, 0, -1, $sformatf("wrap%0d", i));
        chk("instret_wrap", 32'(bus_if.instret), 32'd0);
        run_instr(fbit(F_ALUREG), 3'd0, 0, 0, -1, "after_wrap");

        // Randomized instruction mix.
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 19);
            if (r < 17) begin
                fl = fbit(r % 9);
            end else if (r == 17) begin
                fl = fbit(F_SYSTEM);
            end else if (r == 18) begin
                a  = $urandom_range(0, 9);
                b  = (a + $urandom_range(1, 9)) % 10;
                fl = fbit(a) | fbit(b);
            end else begin
                fl = 10'($urandom);
            end
            f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
            df = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TIMEOUT + 1) : $urandom_range(0, 1);
            dm = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TIMEOUT + 1) : $urandom_range(0, 2);
            if ($urandom_range(0, 49) == 0)
                run_instr(fl, f3, df, dm, $urandom_range(1, 4), $sformatf("rnd%0d_cut", n));
            else
                run_instr(fl, f3, df, dm, -1, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
